// File: rtl/aes_shift_rows_unit.sv
// Registered AES ShiftRows / InvShiftRows engine for NB = 4, 6 or 8 columns.
// The permuted block and its direction tag go into a 2-entry valid/ready FIFO.
module aes_shift_rows_unit #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inverse,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic              out_inverse,
  output logic [CNT_W-1:0]  blk_count
);

  localparam int W = 32 * NB;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $fatal(1, "aes_shift_rows_unit: NB must be 4, 6 or 8");
    end
  endgenerate

  // Rijndael row offsets; the wide 256-bit state uses larger shifts on rows 2 and 3.
  function automatic int rowShift(input int r);
    int s;
    case (r)
      0:       s = 0;
      1:       s = 1;
      2:       s = (NB == 8) ? 3 : 2;
      default: s = (NB == 8) ? 4 : 3;
    endcase
    return s;
  endfunction

  logic [W-1:0] permData;

  // Pure wiring: each output byte picks one of two fixed source columns.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int Shift  = rowShift(r);
      localparam int FwdSrc = (c + Shift) % NB;
      localparam int InvSrc = (c + NB - Shift) % NB;
      assign permData[W-1-8*(4*c+r) -: 8] = inverse ? in_data[W-1-8*(4*InvSrc+r) -: 8]
                                                    : in_data[W-1-8*(4*FwdSrc+r) -: 8];
    end
  end

  logic [W-1:0]     dataMem_q [2];
  logic [1:0]       tagMem_q;
  logic             headPtr_q, headPtr_d;
  logic             tailPtr_q, tailPtr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] blkCount_q, blkCount_d;
  logic             push, pop;

  assign in_ready    = (count_q != 2'd2) && !flush;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = dataMem_q[headPtr_q];
  assign out_inverse = tagMem_q[headPtr_q];
  assign blk_count   = blkCount_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Flush overrides any push/pop in the same cycle; push is already blocked via in_ready.
  always_comb begin
    headPtr_d  = headPtr_q;
    tailPtr_d  = tailPtr_q;
    count_d    = count_q;
    blkCount_d = blkCount_q;
    if (flush) begin
      headPtr_d  = 1'b0;
      tailPtr_d  = 1'b0;
      count_d    = 2'd0;
      blkCount_d = '0;
    end else begin
      if (push) begin
        tailPtr_d  = ~tailPtr_q;
        blkCount_d = blkCount_q + CNT_W'(1);
      end
      if (pop) begin
        headPtr_d = ~headPtr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr_q  <= 1'b0;
      tailPtr_q  <= 1'b0;
      count_q    <= 2'd0;
      blkCount_q <= '0;
    end else begin
      headPtr_q  <= headPtr_d;
      tailPtr_q  <= tailPtr_d;
      count_q    <= count_d;
      blkCount_q <= blkCount_d;
    end
  end

  // Tags are reset so out_inverse reads 0 after reset; the wide data storage is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tagMem_q <= 2'b00;
    end else if (push) begin
      tagMem_q[tailPtr_q] <= inverse;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dataMem_q[tailPtr_q] <= permData;
    end
  end

endmodule
